// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    // addi x0, x0, 0 -- returned after reset and for faulted fetches
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and load-port signals between datapath and responder.
interface imem_fetch_responder_if;
    import imem_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_instr;
    logic            rsp_fault;
    logic            load_we;
    logic [XLEN-1:0] load_addr;
    logic [XLEN-1:0] load_data;

    // Datapath / boot-loader side
    modport master (
        output req_valid, req_addr, rsp_ready, load_we, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready, load_we, load_addr, load_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// A read and write to the same index on one edge returns the old word.
// Contents are not reset; only the read-data register is.
module imem_array
    import imem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_data
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Write port, no reset on storage
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port; non-blocking sampling gives read-before-write on collision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= NOP_INSTR;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: one outstanding fetch, WAIT_STATES extra
// cycles of latency, response held until consumed. Independent load port.
// Optional build macro IMEM_FAULT_CHECK_EN: misaligned or out-of-range fetches
// complete with rsp_fault=1 and a NOP instead of reading the array.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    imem_fetch_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_SPAN = DEPTH_WORDS * 4;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    fetch_state_e          state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  enter_resp_c;
    logic                  fault_c;
    logic                  rd_en_c;
    logic [XLEN-1:0]       fetch_addr_c;
    logic [XLEN-1:0]       arr_rd_data;
    logic                  unused_addr_bits;

    // The array read happens on the edge entering RESP; with zero wait states
    // that is the accept edge, so the address comes straight from the request.
    assign fetch_addr_c = (state_q == ST_IDLE) ? bus.req_addr : addr_q;

    // Fault classification of the address being fetched
`ifdef IMEM_FAULT_CHECK_EN
    assign fault_c = (fetch_addr_c[1:0] != 2'b00) || (fetch_addr_c >= 32'(BYTE_SPAN));
`else
    assign fault_c = 1'b0;
`endif

    assign rd_en_c = enter_resp_c && !fault_c;

    // Address bits outside the word index are deliberately ignored by the array
    assign unused_addr_bits = ^{fetch_addr_c[XLEN-1:IDX_W+2], fetch_addr_c[1:0],
                                bus.load_addr[XLEN-1:IDX_W+2], bus.load_addr[1:0]};

    // Next-state, wait counter and address latch
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        enter_resp_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    cnt_d  = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, address and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

`ifdef IMEM_FAULT_CHECK_EN
    logic fault_q;

    // Fault flag captured alongside the response on the edge entering RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (enter_resp_c) begin
            fault_q <= fault_c;
        end
    end

    assign bus.rsp_fault = fault_q;
    assign bus.rsp_instr = fault_q ? NOP_INSTR : arr_rd_data;
`else
    assign bus.rsp_fault = 1'b0;
    assign bus.rsp_instr = arr_rd_data;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.load_we),
        .wr_idx  (bus.load_addr[IDX_W+1:2]),
        .wr_data (bus.load_data),
        .rd_en   (rd_en_c),
        .rd_idx  (fetch_addr_c[IDX_W+1:2]),
        .rd_data (arr_rd_data)
    );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: one instance with one wait state,
// one with zero wait states. Inputs driven and outputs sampled at negedge.
module tb_imem_fetch_responder;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    imem_fetch_responder_if bus1 ();
    imem_fetch_responder_if bus0 ();

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load1(input logic [31:0] a, input logic [31:0] d);
        bus1.load_we   = 1'b1;
        bus1.load_addr = a;
        bus1.load_data = d;
        @(negedge clk);
        bus1.load_we   = 1'b0;
    endtask

    task automatic load0(input logic [31:0] a, input logic [31:0] d);
        bus0.load_we   = 1'b1;
        bus0.load_addr = a;
        bus0.load_data = d;
        @(negedge clk);
        bus0.load_we   = 1'b0;
    endtask

    // One-wait-state fetch with rsp_ready high: WAIT cycle, RESP cycle, IDLE
    task automatic fetch1(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_instr, input logic exp_fault);
        chk({tag, "_rdy_idle"}, 32'(bus1.req_ready), 32'd1);
        bus1.req_valid = 1'b1;
        bus1.req_addr  = a;
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk({tag, "_wait_valid"}, 32'(bus1.rsp_valid), 32'd0);
        chk({tag, "_wait_rdy"}, 32'(bus1.req_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus1.rsp_valid), 32'd1);
        chk({tag, "_instr"}, bus1.rsp_instr, exp_instr);
        chk({tag, "_fault"}, 32'(bus1.rsp_fault), 32'(exp_fault));
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(bus1.rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp0 [3];
        logic [31:0] exp_wrap;
        logic        exp_flt;

        n_vec = 0;
        n_err = 0;
        reset_n = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.rsp_ready = 1'b0;
        bus1.load_we   = 1'b0; bus1.load_addr = '0; bus1.load_data = '0;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.rsp_ready = 1'b0;
        bus0.load_we   = 1'b0; bus0.load_addr = '0; bus0.load_data = '0;
        #2 reset_n = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_rdy", 32'(bus1.req_ready), 32'd1);
        chk("rst_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("rst_instr", bus1.rsp_instr, 32'h0000_0013);
        chk("rst_fault", 32'(bus1.rsp_fault), 32'd0);
        chk("rst0_instr", bus0.rsp_instr, 32'h0000_0013);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Program words
        load1(32'h0, 32'h0050_0093);
        load1(32'h4, 32'h00A0_0113);
        load1(32'h8, 32'h0000_0013);

        // Basic fetches
        fetch1("f0", 32'h0, 32'h0050_0093, 1'b0);
        fetch1("f4", 32'h4, 32'h00A0_0113, 1'b0);

        // Backpressure: response held, no second accept
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 32'h4;
        bus1.rsp_ready = 1'b0;
        @(negedge clk);
        bus1.req_addr  = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus1.rsp_valid), 32'd1);
            chk("hold_instr", bus1.rsp_instr, 32'h00A0_0113);
            chk("hold_rdy", 32'(bus1.req_ready), 32'd0);
            @(negedge clk);
        end
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("rel_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("rel_rdy", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        chk("rel_no_2nd", 32'(bus1.rsp_valid), 32'd0);

        // Load collides with the read on the edge entering RESP
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 32'h8;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.load_we   = 1'b1;
        bus1.load_addr = 32'h8;
        bus1.load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus1.load_we   = 1'b0;
        chk("col_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("col_instr", bus1.rsp_instr, 32'h0000_0013);
        @(negedge clk);
        fetch1("refetch8", 32'h8, 32'hDEAD_BEEF, 1'b0);

        // Illegal / wrapping addresses
`ifdef IMEM_FAULT_CHECK_EN
        exp_wrap = 32'h0000_0013;
        exp_flt  = 1'b1;
`else
        exp_wrap = 32'h0050_0093;
        exp_flt  = 1'b0;
`endif
        fetch1("a400", 32'h400, exp_wrap, exp_flt);
        fetch1("a2", 32'h2, exp_wrap, exp_flt);
        fetch1("a4_ok", 32'h4, 32'h00A0_0113, 1'b0);

        // Reset during WAIT discards the fetch
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 32'h4;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("mid_rst_rdy", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus1.rsp_valid), 32'd0);
            chk("post_rst_instr", bus1.rsp_instr, 32'h0000_0013);
        end

        // Zero wait states, back-to-back fetches, one response every 2 cycles
        load0(32'h0, 32'h1111_1111);
        load0(32'h4, 32'h2222_2222);
        load0(32'h8, 32'h3333_3333);
        exp0[0] = 32'h1111_1111;
        exp0[1] = 32'h2222_2222;
        exp0[2] = 32'h3333_3333;
        bus0.rsp_ready = 1'b1;
        bus0.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.req_addr = 32'(i * 4);
            chk("b2b_rdy_idle", 32'(bus0.req_ready), 32'd1);
            chk("b2b_idle_valid", 32'(bus0.rsp_valid), 32'd0);
            @(negedge clk);
            chk("b2b_valid", 32'(bus0.rsp_valid), 32'd1);
            chk("b2b_instr", bus0.rsp_instr, exp0[i]);
            chk("b2b_rdy_resp", 32'(bus0.req_ready), 32'd0);
            if (i == 2) bus0.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_valid", 32'(bus0.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
